// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/grant bus with in-order read responses.
// The fetch stage is the master; the memory (or bench) is the slave.
interface fetch_cycle_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_cycle.sv
// RV32I fetch stage: PC, credit-limited pipelined imem requests, prefetch queue, IF/ID register.
// Optional FETCH_PERF_EN adds bubble and redirect performance counters.
module fetch_cycle #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic         clk,
   input  logic         rst,
   fetch_cycle_if.master imem,
   input  logic         StallD,
   input  logic         flag,
   input  logic         PCSrcE,
   input  logic [31:0]  PCTargetE,
   output logic [31:0]  InstrD,
   output logic [31:0]  PCD,
   output logic [31:0]  PCPlus4D,
   output logic         ValidD
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_bubble_cnt,
   output logic [31:0]  perf_redirect_cnt
`endif
);

   localparam int          PW     = $clog2(QDEPTH);
   localparam int          CW     = PW + 1;
   localparam logic [CW:0] QD_EXT = (CW + 1)'(QDEPTH);
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic [31:0]   pc_fetch_q, pc_fetch_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   q_pc_q [QDEPTH];
   logic [31:0]   q_pc_d [QDEPTH];
   logic [31:0]   q_instr_q [QDEPTH];
   logic [31:0]   q_instr_d [QDEPTH];
   logic          issue_en_q;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pcd_q, pcd_d;
   logic [31:0]   pc4_q, pc4_d;
   logic          valid_q, valid_d;
   logic          fire, push, pop, load_bubble;

   // issue_en_q keeps imem_req low for the reset cycle itself
   assign imem.req  = issue_en_q && !PCSrcE &&
                      (({1'b0, outstanding_q} + {1'b0, count_q}) < QD_EXT);
   assign imem.addr = pc_fetch_q;
   assign fire      = imem.req && imem.gnt;

   assign InstrD   = instr_q;
   assign PCD      = pcd_q;
   assign PCPlus4D = pc4_q;
   assign ValidD   = valid_q;

   always_comb begin
      pc_fetch_d    = pc_fetch_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CW'(fire) - CW'(imem.rvalid);
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      q_pc_d        = q_pc_q;
      q_instr_d     = q_instr_q;
      push          = 1'b0;
      pop           = 1'b0;

      // A redirect flushes everything; responses still in flight become drop credits
      if (PCSrcE) begin
         pc_fetch_d = PCTargetE & 32'hFFFF_FFFC;
         resp_pc_d  = PCTargetE & 32'hFFFF_FFFC;
         drop_cnt_d = outstanding_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (fire) pc_fetch_d = pc_fetch_q + 32'd4;
         if (imem.rvalid) begin
            if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
            else                  push       = 1'b1;
         end
         pop = !flag && !StallD && (count_q != '0);
         if (push) begin
            q_pc_d[wr_ptr_q]    = resp_pc_q;
            q_instr_d[wr_ptr_q] = imem.rdata;
            wr_ptr_d            = wr_ptr_q + 1'b1;
            resp_pc_d           = resp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      instr_d     = instr_q;
      pcd_d       = pcd_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      load_bubble = 1'b0;
      if (PCSrcE || flag)        load_bubble = 1'b1;
      else if (StallD)           load_bubble = 1'b0;
      else if (count_q != '0) begin
         instr_d = q_instr_q[rd_ptr_q];
         pcd_d   = q_pc_q[rd_ptr_q];
         pc4_d   = q_pc_q[rd_ptr_q] + 32'd4;
         valid_d = 1'b1;
      end else                   load_bubble = 1'b1;
      if (load_bubble) begin
         instr_d = NOP;
         pcd_d   = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_fetch_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc_q[i]    <= '0;
            q_instr_q[i] <= '0;
         end
         issue_en_q    <= 1'b0;
         instr_q       <= NOP;
         pcd_q         <= '0;
         pc4_q         <= '0;
         valid_q       <= 1'b0;
      end else begin
         pc_fetch_q    <= pc_fetch_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         q_pc_q        <= q_pc_d;
         q_instr_q     <= q_instr_d;
         issue_en_q    <= 1'b1;
         instr_q       <= instr_d;
         pcd_q         <= pcd_d;
         pc4_q         <= pc4_d;
         valid_q       <= valid_d;
      end
   end

   // The issue credit (outstanding + queued <= QDEPTH) must make this unreachable
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      push |-> (count_q < CW'(QDEPTH)));

`ifdef FETCH_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   always_comb begin
      bubble_cnt_d   = bubble_cnt_q + ((load_bubble && !StallD) ? 32'd1 : 32'd0);
      redirect_cnt_d = redirect_cnt_q + (PCSrcE ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         bubble_cnt_q   <= bubble_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign perf_bubble_cnt   = bubble_cnt_q;
   assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: a responder model returns addr^A5A5_0000 in order,
// and a PC scoreboard checks every instruction that lands in IF/ID.
module tb_fetch_cycle;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        StallD, flag, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_bubble_cnt, perf_redirect_cnt;
`endif

   fetch_cycle_if imem_bus ();

   fetch_cycle #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .imem      (imem_bus.master),
      .StallD    (StallD),
      .flag      (flag),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
      ,
      .perf_bubble_cnt   (perf_bubble_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   int          compared   = 0;
   int          mismatched = 0;
   int          consumed   = 0;
   logic [31:0] expPc      = 32'h0;
   logic [31:0] lastPc     = 32'h0;
   logic        lastFired  = 1'b0;
   logic        respEn     = 1'b1;
   logic [31:0] pendAddr [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: responder and inputs change at negedge, IF/ID is scored #1 after posedge
   task automatic applyStimulus(input logic g, input logic st, input logic fl,
                                input logic ps, input logic [31:0] tgt);
      @(negedge clk);
      if (respEn && pendAddr.size() > 0) begin
         imem_bus.rvalid = 1'b1;
         imem_bus.rdata  = pendAddr.pop_front() ^ K;
      end else begin
         imem_bus.rvalid = 1'b0;
         imem_bus.rdata  = 32'h0;
      end
      imem_bus.gnt = g;
      StallD       = st;
      flag         = fl;
      PCSrcE       = ps;
      PCTargetE    = tgt;
      #1;
      lastFired = imem_bus.req && imem_bus.gnt;
      if (lastFired) pendAddr.push_back(imem_bus.addr);
      @(posedge clk);
      #1;
      if (!st && ValidD) begin
         checkOutput("pcd", PCD, expPc);
         checkOutput("instr", InstrD, expPc ^ K);
         checkOutput("pc4", PCPlus4D, expPc + 32'd4);
         lastPc = PCD;
         expPc  = expPc + 32'd4;
         consumed++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0;
      rst = 1'b0;
      imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
      StallD = 1'b0; flag = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("rstInstr", InstrD, NOP);
      checkOutput("rstPcd", PCD, 32'h0);
      checkOutput("rstPc4", PCPlus4D, 32'h0);
      checkOutput("rstValid", {31'b0, ValidD}, 32'h0);
      checkOutput("rstReq", {31'b0, imem_bus.req}, 32'h0);
      checkOutput("rstAddr", imem_bus.addr, 32'h0);
      rst = 1'b1;

      // Startup latency: grant at G, IF/ID valid after G+2
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         if (lastFired) break;
      end
      checkOutput("firstGrant", {31'b0, lastFired}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("validG1", {31'b0, ValidD}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("validG2", {31'b0, ValidD}, 32'h1);
      checkOutput("firstPcd", PCD, 32'h0);

      for (int i = 0; i < 20; i++) begin
         if (consumed > 0 && lastPc == 32'hC) break;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      checkOutput("reach0C", lastPc, 32'hC);

      // Stall: IF/ID frozen at 0xC while the queue fills and requests stop
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("stallPcd", PCD, 32'hC);
         checkOutput("stallInstr", InstrD, 32'hC ^ K);
         checkOutput("stallValid", {31'b0, ValidD}, 32'h1);
      end
      checkOutput("stallReq", {31'b0, imem_bus.req}, 32'h0);

      // Flush for one cycle: bubble, then the queued 0x10 is still delivered
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("flagValid", {31'b0, ValidD}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("flagNextValid", {31'b0, ValidD}, 32'h1);
      checkOutput("flagNextPcd", PCD, 32'h10);

      for (int i = 0; i < 20; i++) begin
         if (imem_bus.addr == 32'h20) break;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      checkOutput("addr20", imem_bus.addr, 32'h20);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         checkOutput("gntLowAddr", imem_bus.addr, 32'h20);
      end
      checkOutput("gntLowReq", {31'b0, imem_bus.req}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("gntResume", imem_bus.addr, 32'h24);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Redirect with two requests outstanding: both stale responses are dropped
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      respEn = 1'b0;
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("pendTwo", pendAddr.size(), 32'd2);
      respEn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
      expPc = 32'h100;
      checkOutput("redirAddr", imem_bus.addr, 32'h100);
      checkOutput("redirValid", {31'b0, ValidD}, 32'h0);
      c0 = consumed;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         if (consumed != c0) break;
      end
      checkOutput("redirFirst", lastPc, 32'h100);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Asynchronous reset with two requests outstanding
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      respEn = 1'b0;
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      imem_bus.gnt = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("midRstInstr", InstrD, NOP);
      checkOutput("midRstPcd", PCD, 32'h0);
      checkOutput("midRstPc4", PCPlus4D, 32'h0);
      checkOutput("midRstValid", {31'b0, ValidD}, 32'h0);
      checkOutput("midRstReq", {31'b0, imem_bus.req}, 32'h0);
      pendAddr.delete();
      respEn = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      expPc = 32'h0;
      #1;
      checkOutput("postRstAddr", imem_bus.addr, 32'h0);
      c0 = consumed;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         if (consumed != c0) break;
      end
      checkOutput("postRstFirst", lastPc, 32'h0);
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("postRstProgress", {31'b0, (consumed - c0) >= 3}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the PC and issues pipelined requests to instruction memory using a request/grant and in-order response handshake. Responses are buffered in a small prefetch queue. The block drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D) consumed by decode. It handles stall, flush and execute-stage branch/jump redirects, discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, prefetch queue entries and the maximum outstanding requests; power of 2, >=2

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  request accepted this cycle when imem_req&imem_gnt
imem_rvalid  input  1  read data valid; responses return in order, earliest the cycle after grant
imem_rdata  input  32  instruction word
StallD  input  1  hold IF/ID contents (decode hazard)
flag  input  1  flush IF/ID (same flush that clears decode's ID/EX register)
PCSrcE  input  1  redirect request from execute
PCTargetE  input  32  redirect target; bits [1:0] forced to 0
InstrD  output  32  instruction to decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD+4
ValidD  output  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset is asynchronous and active-low on rst; clock is clk. At reset: pc_fetch=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0, imem_req=0 (combinational from registered state, so it is 0 while rst is low).
- Issue: imem_req = !PCSrcE && (outstanding + qcount < QDEPTH). imem_addr = pc_fetch. On req&gnt: pc_fetch += 4 (32-bit wrap), outstanding++.
- req held with gnt low: imem_addr stays stable; no state change.
- Response, rvalid=1: outstanding--. If drop_cnt>0: drop_cnt-- and discard the data. Otherwise push {resp_pc, rdata} into the queue and resp_pc += 4.
- Credit rule: the queue never overflows. Any push while full is a design error; flag it with an assertion.
- Redirect, PCSrcE=1, takes priority over everything:
  - pc_fetch <= target; resp_pc <= target; queue cleared.
  - drop_cnt <= outstanding after this cycle's response decrement. A response arriving in the same cycle is dropped.
  - No request is issued that cycle.
  - IF/ID is loaded with a bubble.
- IF/ID register update, priority order:
  - PCSrcE or flag: bubble (InstrD=NOP, ValidD=0, PCD/PCPlus4D=0). No pop, so with flag alone no queued instruction is lost.
  - else StallD: hold all IF/ID outputs; no pop.
  - else queue non-empty: pop; InstrD=entry.instr, PCD=entry.pc, PCPlus4D=entry.pc+4, ValidD=1.
  - else: bubble.
- No queue bypass. Grant at cycle G, rvalid at G+1, queue holds the entry after the G+1 edge, IF/ID after the G+2 edge. Steady state with gnt=1 and 1-cycle response: one valid instruction per cycle.
- Simultaneous push and pop on the same queue: both happen, qcount unchanged.

Optional Feature:
FETCH_PERF_EN
- Defined: adds ports perf_bubble_cnt (output, 32) and perf_redirect_cnt (output, 32), both reset to 0.
  - perf_bubble_cnt increments each cycle IF/ID loads a bubble and StallD=0.
  - perf_redirect_cnt increments each cycle PCSrcE=1.
  - Both wrap at 2^32.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after grant, rdata=addr^32'hA5A5_0000 -> ValidD first rises 3 cycles after the first grant. PCD then reads 0,4,8,... every cycle, PCPlus4D=PCD+4, InstrD matches.
- StallD=1 for 4 cycles in steady state -> InstrD/PCD frozen; queue fills to 2; imem_req=0 once outstanding+qcount=2. After release, PCD continues at the next sequential address with no gap or duplicate.
- PCSrcE=1 with PCTargetE=32'h0000_0102 while 2 requests are outstanding -> both stale responses discarded; next ValidD=1 has PCD=32'h0000_0100; imem_addr=0x100 the cycle after redirect.
- flag=1 for 1 cycle, PCSrcE=0, queue holding PC 0x10 -> ValidD=0 for that cycle; next valid PCD=0x10.
- gnt=0 for 3 cycles with req=1 at addr 0x20 -> imem_addr held at 0x20; after grant, sequence resumes 0x20,0x24.
- rst asserted mid-stream with 2 outstanding -> all outputs at reset values immediately. After release, the first fetch address is RESET_PC. Responses returning after reset are not counted toward the credit limit, so the bench must not return any.
